// File: rtl/osc_pkg.sv
// Shared oscilloscope definitions, used by the sampler and by the readout path.
//   SAMPLE_DEPTH : sample buffer address width (buffer holds 2^SAMPLE_DEPTH bytes)
//   PRE_TRIG     : number of samples streamed before the trigger sample
//   FRAME_HEADER : first byte of every readout frame
//   readout_state_e : readout FSM states
package osc_pkg;

  localparam int         SAMPLE_DEPTH = 8;
  localparam int         PRE_TRIG     = 128;
  localparam logic [7:0] FRAME_HEADER = 8'hA5;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_HEADER = 2'd1,
    RD_STREAM = 2'd2,
    RD_FINISH = 2'd3
  } readout_state_e;

endpackage

// File: rtl/readout_fifo.sv
// Two-entry, 8-bit fall-through FIFO between the sample RAM and the byte stream.
//   clk_50mhz, reset (async, active-low)
//   wr_en / wr_data : push one byte (read data returning from the RAM)
//   rd_en           : pop the head byte
//   rd_data         : head byte; when empty it shows wr_data so a byte can be
//                     written and consumed in the same cycle
//   count, full, empty : occupancy of the stored entries
module readout_fifo (
  input  logic       clk_50mhz,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  logic [7:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       bypass;
  logic       do_wr;
  logic       do_rd;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  // Empty FIFO with a byte arriving and leaving in the same cycle: nothing is stored.
  assign bypass  = empty && wr_en && rd_en;
  assign do_wr   = wr_en && !bypass && (!full || rd_en);
  assign do_rd   = rd_en && !empty;
  assign rd_data = empty ? wr_data : mem[rd_ptr];

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      mem[0] <= 8'h00;
      mem[1] <= 8'h00;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= !wr_ptr;
      end
      if (do_rd) begin
        rd_ptr <= !rd_ptr;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sample_readout.sv
// Streams one captured buffer as a frame: FRAME_HEADER followed by all
// 2^SAMPLE_DEPTH samples, oldest first, starting PRE_TRIG samples before the
// trigger address.
//   clk_50mhz, reset (async, active-low)
//   start, trig_addr        : frame request from the sampler (trig_addr latched on start)
//   mem_addr, mem_re        : sample RAM read port; mem_data valid one cycle after mem_re
//   out_data, out_valid, out_ready, out_last : byte stream to the UART
//   busy, done              : frame in progress / one-cycle completion pulse
//   dbg_state               : current readout FSM state
//
// Stream handshake: a byte transfers on a rising edge where out_valid and
// out_ready are both 1. Once out_valid rises it stays high, with out_data and
// out_last unchanged, until that transfer happens; out_ready may toggle freely.
module sample_readout #(
  parameter int         SAMPLE_DEPTH = osc_pkg::SAMPLE_DEPTH,
  parameter int         PRE_TRIG     = osc_pkg::PRE_TRIG,
  parameter logic [7:0] FRAME_HEADER = osc_pkg::FRAME_HEADER
) (
  input  logic                    clk_50mhz,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SAMPLE_DEPTH-1:0] trig_addr,
  output logic [SAMPLE_DEPTH-1:0] mem_addr,
  output logic                    mem_re,
  input  logic [7:0]              mem_data,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              dbg_state
);

  localparam logic [SAMPLE_DEPTH-1:0] PRE_OFS  = SAMPLE_DEPTH'(PRE_TRIG);
  localparam logic [SAMPLE_DEPTH-1:0] EMIT_ONE = SAMPLE_DEPTH'(1);
  localparam logic [SAMPLE_DEPTH:0]   RD_ONE   = (SAMPLE_DEPTH + 1)'(1);

  osc_pkg::readout_state_e state;

  logic [SAMPLE_DEPTH-1:0] base;
  logic [SAMPLE_DEPTH:0]   rd_cnt;     // MSB set once every sample has been requested
  logic [SAMPLE_DEPTH-1:0] emit_cnt;   // samples already handed to the consumer
  logic                    inflight;   // a read was issued last cycle; mem_data is live

  logic [7:0] fifo_head;
  logic [1:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_rd;
  logic       fifo_has_room;
  logic       stream_valid;
  logic       last_slot;
  logic       rd_phase;
  logic [2:0] occ_net;

  readout_fifo u_fifo (
    .clk_50mhz (clk_50mhz),
    .reset     (reset),
    .wr_en     (inflight),
    .wr_data   (mem_data),
    .rd_en     (fifo_rd),
    .rd_data   (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rd_phase     = (state == osc_pkg::RD_HEADER) || (state == osc_pkg::RD_STREAM);
  // The head is usable when something is stored or the RAM is returning a byte now.
  assign stream_valid = (state == osc_pkg::RD_STREAM) && (!fifo_empty || inflight);
  assign last_slot    = (emit_cnt == {SAMPLE_DEPTH{1'b1}});
  assign fifo_rd      = stream_valid && out_ready;

  assign out_valid = (state == osc_pkg::RD_HEADER) || stream_valid;
  assign out_data  = (state == osc_pkg::RD_HEADER) ? FRAME_HEADER :
                     stream_valid                  ? fifo_head    : 8'h00;
  assign out_last  = stream_valid && last_slot;

  // Occupancy after this cycle's pop, counting the byte landing from the RAM now.
  // Keeping it below 2 guarantees the byte requested now always has a slot.
  assign occ_net       = 3'(fifo_count) + 3'(inflight) - 3'(fifo_rd);
  assign fifo_has_room = !fifo_full || fifo_rd;
  assign mem_re        = rd_phase && !rd_cnt[SAMPLE_DEPTH] && (occ_net < 3'd2) && fifo_has_room;
  assign mem_addr      = base + rd_cnt[SAMPLE_DEPTH-1:0];

  assign busy      = (state != osc_pkg::RD_IDLE);
  assign done      = (state == osc_pkg::RD_FINISH);
  assign dbg_state = state;

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state    <= osc_pkg::RD_IDLE;
      base     <= '0;
      rd_cnt   <= '0;
      emit_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= mem_re;
      if (mem_re) begin
        rd_cnt <= rd_cnt + RD_ONE;
      end
      case (state)
        osc_pkg::RD_IDLE: begin
          if (start) begin
            base     <= trig_addr - PRE_OFS;
            rd_cnt   <= '0;
            emit_cnt <= '0;
            state    <= osc_pkg::RD_HEADER;
          end
        end
        osc_pkg::RD_HEADER: begin
          if (out_ready) begin
            state <= osc_pkg::RD_STREAM;
          end
        end
        osc_pkg::RD_STREAM: begin
          if (fifo_rd) begin
            emit_cnt <= emit_cnt + EMIT_ONE;
            if (last_slot) begin
              state <= osc_pkg::RD_FINISH;
            end
          end
        end
        default: begin
          state <= osc_pkg::RD_IDLE;
        end
      endcase
    end
  end

endmodule
